trigger_scheduler: RTL
======================

TRIGGER_SCHEDULER -- requirements
Module: trigger_scheduler

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of trigger requesters.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 31: max cycles waiting for is_trigger.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src_req  input  N_SRC  single-cycle trigger requests, one bit per source.
REQ-006 SHALL have port src_enable  input  N_SRC  per-source enable mask.
REQ-007 SHALL have port holdoff_cycles  input  16  dead time after each completed trigger.
REQ-008 SHALL have port is_trigger  input  1  trigger-active indication from the trigger FSM.
REQ-009 SHALL have port err_clear  input  1  clears err_timeout and drop_count.
REQ-010 SHALL have port trigger_pulse  output  1  one-cycle start pulse to the trigger FSM.
REQ-011 SHALL have port grant_id  output  $clog2(N_SRC)  source currently being served.
REQ-012 SHALL have port trig_done  output  1  one-cycle pulse when served trigger completes.
REQ-013 SHALL have port err_timeout  output  1  sticky; is_trigger not seen within ACK_TIMEOUT.
REQ-014 SHALL have port drop_count  output  8  saturating count of cycles with a lost request.

Function
REQ-015 SHALL set pending[i] when src_req[i] & src_enable[i]; SHALL clear pending[i] whenever src_enable[i]=0.
REQ-016 SHALL, when src_req[i] & src_enable[i] while pending[i] already set and not granted that cycle, increment drop_count by 1 per cycle (not per source), saturating at 255.
REQ-017 SHALL give a new request priority over a grant clear on the same source in the same cycle (pending stays set).
REQ-018 SHALL implement states IDLE, WAIT_ACK, ACTIVE, HOLDOFF.
REQ-019 IDLE: if any pending, SHALL pick source by round-robin starting at last_grant+1 (wrap at N_SRC), register grant_id, clear its pending bit, assert trigger_pulse on the next cycle for exactly one cycle, go WAIT_ACK; else stay IDLE.
REQ-020 WAIT_ACK: is_trigger=1 -> ACTIVE; ack counter reaching ACK_TIMEOUT with is_trigger=0 -> set err_timeout, go HOLDOFF; else stay.
REQ-021 ACTIVE: is_trigger=0 -> assert trig_done one cycle, load holdoff counter with holdoff_cycles, go HOLDOFF.
REQ-022 HOLDOFF: decrement counter each cycle; at zero -> IDLE; holdoff_cycles=0 SHALL return to IDLE the cycle after entry.
REQ-023 SHALL sample holdoff_cycles only on HOLDOFF entry; later changes have no effect on the running dead time.
REQ-024 SHALL keep grant_id stable from grant until return to IDLE.
REQ-025 SHALL never issue trigger_pulse outside IDLE->WAIT_ACK transition; requests arriving in other states only pend.
REQ-026 err_clear SHALL zero err_timeout and drop_count next cycle; simultaneous timeout and err_clear leaves err_timeout=1.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Reset SHALL force state IDLE, pending=0, last_grant=N_SRC-1 (source 0 served first), counters=0.
REQ-029 Reset SHALL drive trigger_pulse=0, trig_done=0, grant_id=0, err_timeout=0, drop_count=0.
REQ-030 Reset mid-operation SHALL abandon the current grant with no trig_done pulse.

Structure
REQ-031 State encoding, default N_SRC and ACK_TIMEOUT SHALL live in shared package trigger_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (inputs req vector, last_grant; outputs grant index, valid).

Verification
REQ-033 src_req=0001 once, is_trigger high cycles 3-12, holdoff=5 -> one trigger_pulse, grant_id=0, trig_done once, IDLE 6 cycles after trig_done.
REQ-034 src_req=1111 same cycle, prompt acks -> grants in order 0,1,2,3, each separated by holdoff; drop_count=0.
REQ-035 src_req[2] pulsed 3 times during one ACTIVE phase -> one extra grant to source 2, drop_count=2.
REQ-036 is_trigger held 0 after pulse -> err_timeout=1 after 31 WAIT_ACK cycles, no trig_done; err_clear -> err_timeout=0.
REQ-037 src_enable[1] dropped while pending[1] set -> source 1 never granted.
REQ-038 reset asserted in ACTIVE -> all outputs at reset values immediately, next request granted to source 0.

Source files
------------

// File: rtl/trigger_pkg.sv
// trigger_pkg
//   Shared definitions for the trigger scheduler: scheduler state encoding
//   and the default number of requesters / acknowledge timeout.
package trigger_pkg;

  localparam int DEF_N_SRC       = 4;
  localparam int DEF_ACK_TIMEOUT = 31;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_HOLDOFF  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Searches req starting at last_grant+1,
//   wrapping at N_SRC, and returns the first requesting index.
//   Ports:
//     req        in   N_SRC           request vector
//     last_grant in   $clog2(N_SRC)   index served most recently
//     grant      out  $clog2(N_SRC)   selected index (0 when none)
//     valid      out  1               at least one request present
module rr_arbiter
  import trigger_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] last_grant,
  output logic [$clog2(N_SRC)-1:0] grant,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_SRC);

  logic [IDX_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant is the final (winning) assignment.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N_SRC);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trigger_scheduler.sv
// trigger_scheduler
//   Collects single-cycle trigger requests from N_SRC sources, serves them
//   one at a time in round-robin order, handshakes with the trigger FSM via
//   trigger_pulse / is_trigger, and enforces a dead time after each trigger.
//   Ports:
//     clk            in   1   system clock, rising edge
//     reset          in   1   asynchronous, active-high
//     src_req        in   N   per-source single-cycle requests
//     src_enable     in   N   per-source enable; disabled sources lose pending
//     holdoff_cycles in   16  dead time, sampled on HOLDOFF entry
//     is_trigger     in   1   trigger FSM busy indication
//     err_clear      in   1   clears err_timeout and drop_count
//     trigger_pulse  out  1   one-cycle start pulse
//     grant_id       out  clog2(N) source being served
//     trig_done      out  1   one-cycle completion pulse
//     err_timeout    out  1   sticky acknowledge-timeout flag
//     drop_count     out  8   saturating count of cycles that lost a request
module trigger_scheduler
  import trigger_pkg::*;
#(
  parameter int N_SRC       = DEF_N_SRC,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC-1:0]         src_enable,
  input  logic [15:0]              holdoff_cycles,
  input  logic                     is_trigger,
  input  logic                     err_clear,
  output logic                     trigger_pulse,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     trig_done,
  output logic                     err_timeout,
  output logic [7:0]               drop_count
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  sched_state_t     state;
  logic [N_SRC-1:0] pending;
  logic [IDX_W-1:0] last_grant;
  logic [ACK_W-1:0] ack_cnt;
  logic [15:0]      hold_cnt;

  logic [N_SRC-1:0] arb_req;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic             grant_now;
  logic [N_SRC-1:0] new_req;
  logic [N_SRC-1:0] grant_clr;
  logic [N_SRC-1:0] pending_nxt;
  logic             drop_now;

  // Masking with src_enable keeps a source whose enable drops this cycle
  // from being granted before its pending bit is cleared.
  assign arb_req = pending & src_enable;

  rr_arbiter #(
    .N_SRC(N_SRC)
  ) u_arb (
    .req       (arb_req),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .valid     (arb_valid)
  );

  assign grant_now = (state == ST_IDLE) && arb_valid;
  assign new_req   = src_req & src_enable;

  // A fresh request wins over the grant clearing the same pending bit.
  // A request that finds its bit already pending (and not being granted)
  // is lost; all such losses in one cycle count once.
  always_comb begin
    grant_clr = '0;
    if (grant_now) grant_clr[arb_grant] = 1'b1;
    pending_nxt = ((pending & ~grant_clr) | new_req) & src_enable;
    drop_now    = |(new_req & pending & ~grant_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pending       <= '0;
      last_grant    <= IDX_W'(N_SRC - 1);
      ack_cnt       <= '0;
      hold_cnt      <= '0;
      trigger_pulse <= 1'b0;
      grant_id      <= '0;
      trig_done     <= 1'b0;
      err_timeout   <= 1'b0;
      drop_count    <= '0;
    end else begin
      pending       <= pending_nxt;
      trigger_pulse <= 1'b0;
      trig_done     <= 1'b0;

      if (err_clear)
        drop_count <= '0;
      else if (drop_now && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      // A timeout set below overrides this clear in the same cycle.
      if (err_clear) err_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            grant_id      <= arb_grant;
            last_grant    <= arb_grant;
            trigger_pulse <= 1'b1;
            ack_cnt       <= '0;
            state         <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (is_trigger) begin
            state <= ST_ACTIVE;
          end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            hold_cnt    <= holdoff_cycles;
            state       <= ST_HOLDOFF;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!is_trigger) begin
            trig_done <= 1'b1;
            hold_cnt  <= holdoff_cycles;
            state     <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == 16'd0)
            state <= ST_IDLE;
          else
            hold_cnt <= hold_cnt - 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
